// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//
// Memory-side responder for the data cache. Accepts a 64-bit line read
// (rdEn) or a 32-bit word write (wrEn) and sequences it onto an external
// asynchronous 256K x 16 SRAM. A line read fetches four halfwords from the
// line-aligned base. A word write stores two halfwords from the
// word-aligned base. Every access ends with a one-cycle DONE, where ready
// is high.
//
// Optional build macro:
//   SRAM_BASE_OFFSET_EN - subtract 1024 from the byte address before it is
//                         mapped, so CPU data memory at byte 1024 lands on
//                         SRAM halfword 0.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   rdEn, wrEn    line read / word write request, held until ready
//   address       byte address (bits [18:0] used)
//   writeData     word to write
//   readData      assembled line, little-endian halfwords, registered
//   ready         access complete or interface idle (combinational)
//   SRAM_DQ       bidirectional SRAM data bus
//   SRAM_ADDR     halfword address
//   SRAM_WE_N     write enable, active-low
//   SRAM_OE_N     output enable, active-low
//   SRAM_CE_N/UB_N/LB_N  chip and byte enables, tied active
// ---------------------------------------------------------------------------
module sram_controller #(
    parameter int ACCESS_CYCLES = 2   // clocks per 16-bit access, 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEn,
    input  logic        wrEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [63:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  slot_q,  slot_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [17:0] addr_q,  addr_d;    // latched halfword address
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;

    logic [31:0] req_addr;
    logic        last_cnt;
    logic [17:0] rd_base;
    logic [17:0] wr_base;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_addr_bits;

`ifdef SRAM_BASE_OFFSET_EN
    assign req_addr = address - 32'd1024;
`else
    assign req_addr = address;
`endif

    // Only byte-address bits [18:1] reach the SRAM.
    assign unused_addr_bits = ^{req_addr[31:19], req_addr[0]};

    assign last_cnt = (cnt_q == LAST_CNT);
    assign rd_base  = {addr_q[17:2], 2'b00};
    assign wr_base  = {addr_q[17:1], 1'b0};

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign readData  = rdata_q;

    always_comb begin
        // NOTE: every signal written here is given a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready     = 1'b0;
        SRAM_ADDR = 18'd0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b0;
        dq_oe     = 1'b0;
        dq_out    = 16'd0;

        case (state_q)
            IDLE: begin
                // Ready stays low in the accepting cycle, so the cache never
                // fills from the previous line.
                ready = ~rdEn & ~wrEn;
                if (wrEn) begin
                    addr_d  = req_addr[18:1];
                    wdata_d = writeData;
                    slot_d  = 2'd0;
                    cnt_d   = 3'd0;
                    state_d = WRITE;
                end else if (rdEn) begin
                    addr_d  = req_addr[18:1];
                    slot_d  = 2'd0;
                    cnt_d   = 3'd0;
                    state_d = READ;
                end
            end

            READ: begin
                SRAM_ADDR = rd_base + {16'd0, slot_q};
                if (last_cnt) begin
                    // The bus has settled for ACCESS_CYCLES clocks, so sample it.
                    rdata_d[{slot_q, 4'b0000} +: 16] = SRAM_DQ;
                    cnt_d  = 3'd0;
                    slot_d = slot_q + 2'd1;
                    if (slot_q == 2'd3) state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            WRITE: begin
                SRAM_ADDR = wr_base + {17'd0, slot_q[0]};
                SRAM_WE_N = 1'b0;
                SRAM_OE_N = 1'b1;
                dq_oe     = 1'b1;
                dq_out    = slot_q[0] ? wdata_q[31:16] : wdata_q[15:0];
                if (last_cnt) begin
                    cnt_d  = 3'd0;
                    slot_d = slot_q + 2'd1;
                    if (slot_q[0]) state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments, so every flop samples
    // the values from before this edge, whatever order the statements run in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= 2'd0;
            cnt_q   <= 3'd0;
            addr_q  <= 18'd0;
            wdata_q <= 32'd0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    localparam int A = 2;
    localparam int RD_DONE = 4 * A + 1;
    localparam int WR_DONE = 2 * A + 1;

`ifdef SRAM_BASE_OFFSET_EN
    localparam logic [31:0] OFS = 32'd1024;
`else
    localparam logic [31:0] OFS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdEn, wrEn;
    logic [31:0] address, writeData;
    logic [63:0] readData;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:262143];

    sram_controller #(.ACCESS_CYCLES(A)) dut (
        .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn),
        .address(address), .writeData(writeData),
        .readData(readData), .ready(ready),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: drives the bus while output-enabled and not
    // writing; stores the bus contents while WE_N is low.
    assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz;
    always @(negedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] base;
        logic [63:0] rdata;
        logic [15:0] mem_lo;
        logic [15:0] mem_hi;
    } vec_t;

    vec_t vecs [8];

    // Issue one request from an IDLE cycle (cycle 0), check the SRAM pins in
    // every active cycle, the cycle ready arrives, and the resulting line.
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [17:0] base, input logic [63:0] exp_rd);
        int done_at;
        int exp_done;
        logic [17:0] exp_addr;
        exp_done = wr ? WR_DONE : RD_DONE;
        rdEn = rd; wrEn = wr; address = a; writeData = wd;
        #1 check({tag, "_ready_c0"}, 64'(ready), 64'd0);
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                done_at = k;
                break;
            end
            if (k < exp_done) begin
                exp_addr = base + 18'((k - 1) / A);
                check($sformatf("%s_addr_c%0d", tag, k), 64'(SRAM_ADDR), 64'(exp_addr));
                check($sformatf("%s_we_c%0d", tag, k), 64'(SRAM_WE_N), 64'(!wr));
                check($sformatf("%s_oe_c%0d", tag, k), 64'(SRAM_OE_N), 64'(wr));
            end
        end
        rdEn = 1'b0; wrEn = 1'b0;
        check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
        check({tag, "_rdata"}, readData, exp_rd);
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, 64'(ready), 64'd1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[4] = 16'h5555; mem[5] = 16'h6666; mem[6] = 16'h7777; mem[7] = 16'h8888;
        mem[10] = 16'hA0A0; mem[11] = 16'hB0B0;
        mem[18'h3FFFC] = 16'h0C0C; mem[18'h3FFFD] = 16'h0D0D;
        mem[18'h3FFFE] = 16'h0E0E; mem[18'h3FFFF] = 16'h0F0F;

        //          rd    wr    address           wdata          base      readData after            mem lo/hi
        vecs[0] = '{1'b1, 1'b0, 32'h4 + OFS,      32'h0,         18'd0,    64'h4444_3333_2222_1111, 16'h0,    16'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h10 + OFS,     32'hDEADBEEF,  18'd8,    64'h4444_3333_2222_1111, 16'hBEEF, 16'hDEAD};
        vecs[2] = '{1'b1, 1'b0, 32'h13 + OFS,     32'h0,         18'd8,    64'hB0B0_A0A0_DEAD_BEEF, 16'h0,    16'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h20 + OFS,     32'h12345678,  18'd16,   64'hB0B0_A0A0_DEAD_BEEF, 16'h5678, 16'h1234};
        vecs[4] = '{1'b0, 1'b1, 32'h16 + OFS,     32'hCAFEF00D,  18'd10,   64'hB0B0_A0A0_DEAD_BEEF, 16'hF00D, 16'hCAFE};
        vecs[5] = '{1'b1, 1'b0, 32'h8 + OFS,      32'h0,         18'd4,    64'h8888_7777_6666_5555, 16'h0,    16'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h7FFF8 + OFS,  32'h0,         18'h3FFFC, 64'h0F0F_0E0E_0D0D_0C0C, 16'h0,   16'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h10 + OFS,     32'h0,         18'd8,    64'hCAFE_F00D_DEAD_BEEF, 16'h0,    16'h0};

        // Reset and idle state.
        rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0; address = 32'd0; writeData = 32'd0;
        #12;
        check("rst_we_n", 64'(SRAM_WE_N), 64'd1);
        check("rst_oe_n", 64'(SRAM_OE_N), 64'd0);
        check("rst_addr", 64'(SRAM_ADDR), 64'd0);
        check("rst_rdata", readData, 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_bus_released", 64'(SRAM_DQ), 64'h1111);
        check("rst_ce_ub_lb", 64'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 64'd0);
        rdEn = 1'b1;
        #1 check("rst_ready_drops", 64'(ready), 64'd0);
        rdEn = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 64'(ready), 64'd1);
        check("idle_bus_released", 64'(SRAM_DQ), 64'h1111);

        // Table-driven requests.
        for (int i = 0; i < 8; i++) begin
            run_req($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].wdata, vecs[i].base, vecs[i].rdata);
            if (vecs[i].wr) begin
                check($sformatf("v%0d_mem_lo", i), 64'(mem[vecs[i].base]), 64'(vecs[i].mem_lo));
                check($sformatf("v%0d_mem_hi", i), 64'(mem[vecs[i].base + 18'd1]), 64'(vecs[i].mem_hi));
            end
        end

        // Reset during cycle 3 of a read.
        rdEn = 1'b1; address = 32'h0 + OFS;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrd_we_n", 64'(SRAM_WE_N), 64'd1);
        check("midrd_addr", 64'(SRAM_ADDR), 64'd0);
        check("midrd_rdata", readData, 64'd0);
        check("midrd_ready_req", 64'(ready), 64'd0);
        rdEn = 1'b0;
        #1 check("midrd_ready_idle", 64'(ready), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_req("after_rst", 1'b1, 1'b0, 32'h0 + OFS, 32'h0, 18'd0, 64'h4444_3333_2222_1111);

        // Reset during a write releases the bus immediately.
        wrEn = 1'b1; address = 32'h30 + OFS; writeData = 32'h99998888;
        repeat (2) @(posedge clk);
        #1 check("midwr_we_low", 64'(SRAM_WE_N), 64'd0);
        rst = 1'b1;
        #1;
        check("midwr_we_n", 64'(SRAM_WE_N), 64'd1);
        check("midwr_bus_released", 64'(SRAM_DQ), 64'h1111);
        wrEn = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // A read held high past DONE starts a second read in the next IDLE.
        rdEn = 1'b1; address = 32'h8 + OFS;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ready) begin k = c; break; end
        end
        check("held_first_done", 64'(k), 64'(RD_DONE));
        @(posedge clk); #1;
        check("held_idle_ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        check("held_second_addr", 64'(SRAM_ADDR), 64'd4);
        check("held_second_oe", 64'(SRAM_OE_N), 64'd0);
        rdEn = 1'b0;
        k = 0;
        for (int c = RD_DONE + 3; c <= 60; c++) begin
            @(posedge clk); #1;
            if (ready) begin k = c; break; end
        end
        check("held_second_done", 64'(k), 64'(2 * RD_DONE + 1));
        check("held_second_rdata", readData, 64'h8888_7777_6666_5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
